mc_control_fsm: RTL and testbench

//  Multi-cycle CPU main controller, directly upstream of the ALU. Decodes opcode/funct,

---
 rtl/mc_control_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU main controller: Moore FSM sequencing FETCH..WRITEBACK and driving datapath
// controls. Define TRAP_ILLEGAL_EN to trap illegal instructions into a sticky HALT state.
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       ext_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StRwb    = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StIexec  = 4'd10;
  localparam logic [3:0] StIwb    = 4'd11;
  localparam logic [3:0] StHalt   = 4'd12;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [3:0] MemWaitC = 4'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;
  logic       illegal_q, illegal_d;
  logic       wait_done;
  logic       dec_ok;
  logic [3:0] r_live, r_held;
  logic       unused_zero;

  // zero only qualifies pc_write_cond, and that AND lives in the datapath
  assign unused_zero = zero;
  assign wait_done   = (wait_cnt_q == MemWaitC);

  // {legal, alu_op} for an R-type funct
  function automatic logic [3:0] r_decode(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b100110: return 4'b1_011;
      6'b100111: return 4'b1_100;
      6'b101010: return 4'b1_111;
      6'b000010: return 4'b1_101;
      default:   return 4'b0_010;
    endcase
  endfunction

  assign r_live = r_decode(funct);
  assign r_held = r_decode(fn_q);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    op_d       = op_q;
    fn_d       = fn_q;
    illegal_d  = illegal_q;
    dec_ok     = 1'b1;
    case (state_q)
      StFetch: begin
        if (wait_done) state_d = StDecode;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      StDecode: begin
        op_d = opcode;
        fn_d = funct;
        case (opcode)
          OpRtype: begin
            dec_ok  = r_live[3];
            state_d = StExec;
          end
          OpLw, OpSw:                           state_d = StMemAdr;
          OpBeq:                                state_d = StBranch;
          OpJ:                                  state_d = StJump;
          OpAddi, OpAndi, OpOri, OpXori, OpSlti: state_d = StIexec;
          default:                              dec_ok  = 1'b0;
        endcase
        if (!dec_ok) begin
`ifdef TRAP_ILLEGAL_EN
          state_d   = StHalt;
          illegal_d = 1'b1;
`else
          state_d   = StFetch;
`endif
        end
      end
      StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (wait_done) state_d = StMemWb;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      StMemWr: begin
        if (wait_done) state_d = StFetch;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      StExec:  state_d = StRwb;
      StIexec: state_d = StIwb;
      StMemWb, StRwb, StIwb, StBranch, StJump: state_d = StFetch;
`ifdef TRAP_ILLEGAL_EN
      StHalt:  state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    ext_op        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'b010;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = wait_done;
        pc_write  = wait_done;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = r_held[2:0];
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StIexec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = (op_q == OpAddi) || (op_q == OpSlti);
        case (op_q)
          OpSlti:  alu_op = 3'b111;
          OpAndi:  alu_op = 3'b000;
          OpOri:   alu_op = 3'b001;
          OpXori:  alu_op = 3'b011;
          default: alu_op = 3'b010;
        endcase
      end
      StIwb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b110;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
    // Async reset must not let a strobe escape before the flops settle
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      op_q       <= '0;
      fn_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
      fn_q       <= fn_d;
      illegal_q  <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level model of expected control words per cycle,
// plus a MEM_WAIT=0 instance pinned with literal expectations.
module tb_mc_control_fsm;

  localparam int unsigned MW = 2;
  localparam int NV = 19;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, ext, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       ill;
  } ctl_t;

  typedef enum int {ClsR, ClsLw, ClsSw, ClsBeq, ClsJ, ClsI, ClsIll} cls_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    cls_e       cls;
    logic [2:0] aop;
    logic       ext;
  } vec_t;

  logic clk = 1'b0;
  logic rst, zero;
  logic [5:0] opcode, funct;

  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst;
  logic reg_write, ext_op, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  logic z_pc_write, z_pc_write_cond, z_iord, z_mem_read, z_mem_write, z_ir_write;
  logic z_mem_to_reg, z_reg_dst, z_reg_write, z_ext_op, z_alu_src_a, z_illegal;
  logic [1:0] z_alu_src_b, z_pc_source;
  logic [2:0] z_alu_op;
  logic [3:0] z_state;

  mc_control_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .ext_op(ext_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .state(state), .illegal(illegal)
  );

  mc_control_fsm #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(z_pc_write), .pc_write_cond(z_pc_write_cond), .iord(z_iord),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .ir_write(z_ir_write),
    .mem_to_reg(z_mem_to_reg), .reg_dst(z_reg_dst), .reg_write(z_reg_write),
    .ext_op(z_ext_op), .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b),
    .pc_source(z_pc_source), .alu_op(z_alu_op), .state(z_state), .illegal(z_illegal)
  );

  always #5 clk = ~clk;

  ctl_t act_w;
  assign act_w = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, ext_op, alu_src_a, alu_src_b, pc_source,
                  alu_op, illegal};

  int   checks = 0;
  int   errors = 0;
  int   cur_idx = 0;
  logic model_ill = 1'b0;
  ctl_t exp_q[$];
  vec_t vecs[NV];
  logic [3:0] z_st_exp[5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};

  function automatic ctl_t base(input logic [3:0] st);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.aop = 3'b010;
    c.ill = model_ill;
    return c;
  endfunction

  // Expand one instruction into its expected per-cycle control words
  task automatic push_instr(input vec_t v);
    ctl_t c;
    opcode = v.op;
    funct  = v.fn;
    zero   = 1'($urandom_range(0, 1));
    for (int i = 0; i <= int'(MW); i++) begin
      c = base(4'd0); c.mrd = 1'b1; c.asb = 2'b01;
      if (i == int'(MW)) begin c.irw = 1'b1; c.pcw = 1'b1; end
      exp_q.push_back(c);
    end
    c = base(4'd1); c.asb = 2'b11; exp_q.push_back(c);
    case (v.cls)
      ClsLw, ClsSw: begin
        c = base(4'd2); c.asa = 1'b1; c.asb = 2'b10; c.ext = 1'b1; exp_q.push_back(c);
        for (int i = 0; i <= int'(MW); i++) begin
          c = base((v.cls == ClsLw) ? 4'd3 : 4'd5); c.iord = 1'b1;
          if (v.cls == ClsLw) c.mrd = 1'b1;
          else                c.mwr = 1'b1;
          exp_q.push_back(c);
        end
        if (v.cls == ClsLw) begin
          c = base(4'd4); c.rw = 1'b1; c.m2r = 1'b1; exp_q.push_back(c);
        end
      end
      ClsR: begin
        c = base(4'd6); c.asa = 1'b1; c.aop = v.aop; exp_q.push_back(c);
        c = base(4'd7); c.rw = 1'b1; c.rdst = 1'b1; exp_q.push_back(c);
      end
      ClsI: begin
        c = base(4'd10); c.asa = 1'b1; c.asb = 2'b10; c.ext = v.ext; c.aop = v.aop;
        exp_q.push_back(c);
        c = base(4'd11); c.rw = 1'b1; exp_q.push_back(c);
      end
      ClsBeq: begin
        c = base(4'd8); c.asa = 1'b1; c.aop = 3'b110; c.pcwc = 1'b1; c.pcs = 2'b01;
        exp_q.push_back(c);
      end
      ClsJ: begin
        c = base(4'd9); c.pcw = 1'b1; c.pcs = 2'b10; exp_q.push_back(c);
      end
      default: begin
`ifdef TRAP_ILLEGAL_EN
        model_ill = 1'b1;
        repeat (3) begin c = base(4'd12); exp_q.push_back(c); end
`endif
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ctl_t e;
      e = exp_q.pop_front();
      checks++;
      if (act_w !== e) begin
        errors++;
        $display("FAIL ctl vec %0d st %0d: got %h want %h", cur_idx, e.st, act_w, e);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout vec %0d: left %0d want 0", cur_idx, exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got st %0d ill %b mw %b rw %b want 0 0 0 0",
               state, illegal, mem_write, reg_write);
    end
    checks++;
    if (z_pc_write !== 1'b0 || z_ir_write !== 1'b0 || z_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_wen_forced: got pcw %b irw %b st %0d want 0 0 0",
               z_pc_write, z_ir_write, z_state);
    end
    model_ill = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // MEM_WAIT=0 instance running add straight out of reset
  initial begin
    @(negedge rst);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (z_state !== z_st_exp[i] || z_reg_write !== (i == 3)) begin
        errors++;
        $display("FAIL add_mw0 cyc %0d: got st %0d rw %b want st %0d rw %b",
                 i, z_state, z_reg_write, z_st_exp[i], (i == 3));
      end
      if (i == 2) begin
        checks++;
        if (z_alu_op !== 3'b010) begin
          errors++;
          $display("FAIL add_mw0_aluop: got %b want 010", z_alu_op);
        end
      end
    end
  end

  initial begin
    logic found;
    vecs[0]  = '{6'b000000, 6'b100000, ClsR,   3'b010, 1'b0};
    vecs[1]  = '{6'b000000, 6'b100010, ClsR,   3'b110, 1'b0};
    vecs[2]  = '{6'b000000, 6'b100100, ClsR,   3'b000, 1'b0};
    vecs[3]  = '{6'b000000, 6'b100101, ClsR,   3'b001, 1'b0};
    vecs[4]  = '{6'b000000, 6'b100110, ClsR,   3'b011, 1'b0};
    vecs[5]  = '{6'b000000, 6'b100111, ClsR,   3'b100, 1'b0};
    vecs[6]  = '{6'b000000, 6'b101010, ClsR,   3'b111, 1'b0};
    vecs[7]  = '{6'b000000, 6'b000010, ClsR,   3'b101, 1'b0};
    vecs[8]  = '{6'b100011, 6'b000000, ClsLw,  3'b010, 1'b0};
    vecs[9]  = '{6'b101011, 6'b000000, ClsSw,  3'b010, 1'b0};
    vecs[10] = '{6'b000100, 6'b000000, ClsBeq, 3'b110, 1'b0};
    vecs[11] = '{6'b000010, 6'b000000, ClsJ,   3'b010, 1'b0};
    vecs[12] = '{6'b001000, 6'b000000, ClsI,   3'b010, 1'b1};
    vecs[13] = '{6'b001100, 6'b000000, ClsI,   3'b000, 1'b0};
    vecs[14] = '{6'b001101, 6'b000000, ClsI,   3'b001, 1'b0};
    vecs[15] = '{6'b001110, 6'b000000, ClsI,   3'b011, 1'b0};
    vecs[16] = '{6'b001010, 6'b000000, ClsI,   3'b111, 1'b1};
    vecs[17] = '{6'b000000, 6'b111111, ClsIll, 3'b010, 1'b0};
    vecs[18] = '{6'b111111, 6'b000000, ClsIll, 3'b010, 1'b0};

    rst    = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b100000;
    zero   = 1'b0;
    #1;
    do_reset();

    for (int k = 0; k < NV; k++) begin
      cur_idx = k;
      push_instr(vecs[k]);
      if (vecs[k].cls == ClsLw) begin
        // 3 fetch + decode + memadr + 3 memrd + memwb
        checks++;
        if (exp_q.size() != 9) begin
          errors++;
          $display("FAIL lw_len: got %0d want 9", exp_q.size());
        end
      end
      wait_drain();
`ifdef TRAP_ILLEGAL_EN
      if (vecs[k].cls == ClsIll) do_reset();
`endif
    end

    // Reset in the middle of a store's MEMWR wait
    cur_idx = 100;
    opcode  = 6'b101011;
    funct   = 6'b000000;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (state == 4'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL memwr_reach: got st %0d want 5", state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_write !== 1'b1 || state !== 4'd5) begin
      errors++;
      $display("FAIL memwr_hold: got mw %b st %0d want 1 5", mem_write, state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      errors++;
      $display("FAIL rst_memwr: got mw %b st %0d want 0 0", mem_write, state);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // A full-length fetch afterwards shows the wait counter was cleared
    cur_idx = 101;
    push_instr(vecs[0]);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
